// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry full adder with a one-cycle registered, valid-qualified copy.
// Optional saturating carry counter enabled by defining FULL_ADDER_CARRY_STATS_EN.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q,
  output logic             out_valid
`ifdef FULL_ADDER_CARRY_STATS_EN
  ,
  output logic [15:0]      carry_count
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             valid_reg;

  assign carry[0] = Cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic half_sum;
    assign half_sum      = A[gi] ^ B[gi];
    assign sum_bits[gi]  = half_sum ^ carry[gi];
    assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & half_sum);
  end

  assign Sum  = sum_bits;
  assign Cout = carry[WIDTH];

  // Data registers hold while in_valid is low; only the valid flag follows every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg  <= sum_bits;
        cout_reg <= carry[WIDTH];
      end
    end
  end

  assign Sum_q     = sum_reg;
  assign Cout_q    = cout_reg;
  assign out_valid = valid_reg;

`ifdef FULL_ADDER_CARRY_STATS_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (in_valid && carry[WIDTH] && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign carry_count = count_reg;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16 against an arithmetic reference.
// Carry statistics checks are compiled only when FULL_ADDER_CARRY_STATS_EN is defined.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a1, b1, c1, v1;
  logic       s1, co1, sq1, coq1, ov1;
  logic [7:0] a8, b8, s8, sq8;
  logic       c8, v8, co8, coq8, ov8;
  logic [15:0] a16, b16, s16, sq16;
  logic        c16, v16, co16, coq16, ov16;
`ifdef FULL_ADDER_CARRY_STATS_EN
  logic [15:0] cc1, cc8, cc16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
    .Sum(s1), .Cout(co1), .Sum_q(sq1), .Cout_q(coq1), .out_valid(ov1)
`ifdef FULL_ADDER_CARRY_STATS_EN
    , .carry_count(cc1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(c8), .in_valid(v8),
    .Sum(s8), .Cout(co8), .Sum_q(sq8), .Cout_q(coq8), .out_valid(ov8)
`ifdef FULL_ADDER_CARRY_STATS_EN
    , .carry_count(cc8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(c16), .in_valid(v16),
    .Sum(s16), .Cout(co16), .Sum_q(sq16), .Cout_q(coq16), .out_valid(ov16)
`ifdef FULL_ADDER_CARRY_STATS_EN
    , .carry_count(cc16)
`endif
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp2;
    logic [8:0]  exp9;
    logic [16:0] exp17;
    logic [16:0] held17;
    logic        exp_valid;
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic        vc [3];
    int          carries;

    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    a8 = 0; b8 = 0; c8 = 0; v8 = 0;
    a16 = 0; b16 = 0; c16 = 0; v16 = 0;

    // Reset state, with the combinational path live during reset.
    #2;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    #1;
    check_value("rst_sum_q_w1", {63'd0, sq1}, 64'd0);
    check_value("rst_out_valid_w1", {63'd0, ov1}, 64'd0);
    check_value("rst_sum_q_w16", {48'd0, sq16}, 64'd0);
    check_value("rst_cout_q_w16", {63'd0, coq16}, 64'd0);
    check_value("comb_in_reset_w8", {55'd0, co8, s8}, 64'h047);
    $display("txn reset: comb w8 12+34+1 -> %0h", {co8, s8});

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #1;
      exp2 = 2'(a1) + 2'(b1) + 2'(c1);
      $display("txn w1 abc=%03b -> cout,sum=%02b", i[2:0], {co1, s1});
      check_value("w1_truth", {62'd0, co1, s1}, {62'd0, exp2});
      #9;
    end

    // WIDTH=1 capture then hold.
    @(negedge clk);
    {a1, b1, c1} = 3'b111; v1 = 1'b1;
    @(negedge clk);
    $display("txn w1 capture 111 -> q=%b%b v=%b", coq1, sq1, ov1);
    check_value("w1_cap_sum_q", {63'd0, sq1}, 64'd1);
    check_value("w1_cap_cout_q", {63'd0, coq1}, 64'd1);
    check_value("w1_cap_valid", {63'd0, ov1}, 64'd1);
    {a1, b1, c1} = 3'b000; v1 = 1'b0;
    @(negedge clk);
    $display("txn w1 hold -> q=%b%b v=%b", coq1, sq1, ov1);
    check_value("w1_hold_q", {62'd0, coq1, sq1}, 64'd3);
    check_value("w1_hold_valid", {63'd0, ov1}, 64'd0);

    // WIDTH=8 boundary vectors.
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'h7F; vb[1] = 8'h80; vc[1] = 1'b1;
    va[2] = 8'h12; vb[2] = 8'h34; vc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; c8 = vc[i];
      #1;
      exp9 = 9'(a8) + 9'(b8) + 9'(c8);
      $display("txn w8 %0h+%0h+%0b -> %0h", a8, b8, c8, {co8, s8});
      check_value("w8_comb", {55'd0, co8, s8}, {55'd0, exp9});
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    {a1, b1, c1} = 3'b111; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    check_value("w1_reload_valid", {63'd0, ov1}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async reset -> q=%b%b v=%b comb=%b%b", coq1, sq1, ov1, co1, s1);
    check_value("async_sum_q", {63'd0, sq1}, 64'd0);
    check_value("async_cout_q", {63'd0, coq1}, 64'd0);
    check_value("async_valid", {63'd0, ov1}, 64'd0);
    check_value("async_comb", {62'd0, co1, s1}, 64'd3);
    @(negedge clk);
    rst_n = 1'b1;
    {a1, b1, c1} = 3'b000;

    // Random WIDTH=16 stream with toggling in_valid.
    held17 = '0;
    exp_valid = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      check_value("w16_valid", {63'd0, ov16}, {63'd0, exp_valid});
      check_value("w16_q", {47'd0, coq16, sq16}, {47'd0, held17});
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      v16 = 1'($urandom);
      #1;
      exp17 = 17'(a16) + 17'(b16) + 17'(c16);
      $display("txn w16 %0d a=%04h b=%04h c=%0b v=%0b -> %05h", t, a16, b16, c16, v16, {co16, s16});
      check_value("w16_comb", {47'd0, co16, s16}, {47'd0, exp17});
      exp_valid = v16;
      if (v16) held17 = exp17;
    end
    @(negedge clk);
    check_value("w16_last_q", {47'd0, coq16, sq16}, {47'd0, held17});
    v16 = 1'b0;

`ifdef FULL_ADDER_CARRY_STATS_EN
    rst_n = 1'b0;
    #1;
    check_value("stats_reset", {48'd0, cc1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    carries = 0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: {a1, b1, c1} = 3'b111;
        1: {a1, b1, c1} = 3'b000;
        2: {a1, b1, c1} = 3'b110;
        3: {a1, b1, c1} = 3'b001;
        default: {a1, b1, c1} = 3'b011;
      endcase
      v1 = 1'b1;
      if ((int'(a1) + int'(b1) + int'(c1)) >= 2) carries++;
      @(negedge clk);
    end
    v1 = 1'b0;
    {a1, b1, c1} = 3'b111;
    @(negedge clk);
    $display("txn stats -> carry_count=%0d", cc1);
    check_value("stats_count", {48'd0, cc1}, 64'(carries));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
